// File: rtl/guess_game_ctrl.sv
// Round sequencer for the two-player keypad guessing game: draws a target digit,
// judges guesses, keeps scores, enforces the turn timeout and declares the winner.
module guess_game_ctrl #(
  parameter int WIN_SCORE   = 3,
  parameter int TIMEOUT     = 1000,
  parameter int RESULT_HOLD = 50,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         key_code,
  input  logic [4:0]         rnd,
  output logic               rnd_en,
  output logic               whose,
  output logic               hit,
  output logic               hi,
  output logic               lo,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               winner_valid,
  output logic               winner,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAW     = 3'd1,
    LATCH    = 3'd2,
    WAIT_KEY = 3'd3,
    CHECK    = 3'd4,
    RESULT   = 3'd5,
    OVER     = 3'd6
  } state_t;

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W  = $clog2(RESULT_HOLD + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);

  state_t               state_reg;
  logic [3:0]           prev_key_reg;
  logic [3:0]           target_reg;
  logic [3:0]           guess_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [HOLD_W-1:0]    hold_reg;
  logic                 rnd_en_reg;
  logic                 whose_reg;
  logic                 hit_reg;
  logic                 hi_reg;
  logic                 lo_reg;
  logic [SCORE_W-1:0]   score0_reg;
  logic [SCORE_W-1:0]   score1_reg;
  logic                 winner_valid_reg;
  logic                 winner_reg;

  logic                 digit_evt;
  logic                 star_evt;
  logic                 hash_evt;
  logic [SCORE_W-1:0]   cur_score;

  // Events fire on the first cycle a key appears after "no key"; 12-14 are dead codes.
  always_comb begin
    digit_evt = 1'b0;
    star_evt  = 1'b0;
    hash_evt  = 1'b0;
    if (prev_key_reg == 4'd15) begin
      digit_evt = (key_code <= 4'd9);
      star_evt  = (key_code == 4'd10);
      hash_evt  = (key_code == 4'd11);
    end
  end

  assign cur_score = whose_reg ? score1_reg : score0_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      prev_key_reg     <= 4'd15;
      target_reg       <= '0;
      guess_reg        <= '0;
      timer_reg        <= '0;
      hold_reg         <= '0;
      rnd_en_reg       <= 1'b0;
      whose_reg        <= 1'b0;
      hit_reg          <= 1'b0;
      hi_reg           <= 1'b0;
      lo_reg           <= 1'b0;
      score0_reg       <= '0;
      score1_reg       <= '0;
      winner_valid_reg <= 1'b0;
      winner_reg       <= 1'b0;
    end else begin
      prev_key_reg <= key_code;
      rnd_en_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hash_evt) begin
            score0_reg <= '0;
            score1_reg <= '0;
            whose_reg  <= 1'b0;
            rnd_en_reg <= 1'b1;
            state_reg  <= DRAW;
          end
        end
        DRAW: state_reg <= LATCH;
        LATCH: begin
          target_reg <= 4'(rnd % 5'd10);
          timer_reg  <= '0;
          state_reg  <= WAIT_KEY;
        end
        WAIT_KEY: begin
          timer_reg <= timer_reg + 1'b1;
          // A digit arriving on the timeout cycle still counts as a guess.
          if (digit_evt) begin
            guess_reg <= key_code;
            state_reg <= CHECK;
          end else if (star_evt || timer_reg == TIMER_LAST) begin
            hit_reg   <= 1'b0;
            hi_reg    <= 1'b0;
            lo_reg    <= 1'b0;
            hold_reg  <= '0;
            state_reg <= RESULT;
          end
        end
        CHECK: begin
          hit_reg <= (guess_reg == target_reg);
          hi_reg  <= (guess_reg >  target_reg);
          lo_reg  <= (guess_reg <  target_reg);
          if (guess_reg == target_reg && cur_score < WIN) begin
            if (whose_reg) score1_reg <= score1_reg + SCORE_W'(1);
            else           score0_reg <= score0_reg + SCORE_W'(1);
          end
          hold_reg  <= '0;
          state_reg <= RESULT;
        end
        RESULT: begin
          if (hold_reg == HOLD_LAST) begin
            hit_reg <= 1'b0;
            hi_reg  <= 1'b0;
            lo_reg  <= 1'b0;
            if (cur_score == WIN) begin
              winner_valid_reg <= 1'b1;
              winner_reg       <= whose_reg;
              state_reg        <= OVER;
            end else begin
              whose_reg  <= ~whose_reg;
              rnd_en_reg <= 1'b1;
              state_reg  <= DRAW;
            end
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        OVER: begin
          if (hash_evt) begin
            score0_reg       <= '0;
            score1_reg       <= '0;
            whose_reg        <= 1'b0;
            winner_valid_reg <= 1'b0;
            rnd_en_reg       <= 1'b1;
            state_reg        <= DRAW;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Board LEDs: l0 = rnd_en, l1 = whose, l2 = winner_valid.
  assign rnd_en       = rnd_en_reg;
  assign whose        = whose_reg;
  assign hit          = hit_reg;
  assign hi           = hi_reg;
  assign lo           = lo_reg;
  assign score0       = score0_reg;
  assign score1       = score1_reg;
  assign winner_valid = winner_valid_reg;
  assign winner       = winner_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl (TIMEOUT=20, RESULT_HOLD=4, WIN_SCORE=3).
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'd15;
  logic [4:0] rnd = 5'd0;
  logic       rnd_en, whose, hit, hi, lo, winner_valid, winner;
  logic [3:0] score0, score1;
  logic [2:0] state;
  int n_checks = 0;
  int n_fail = 0;

  guess_game_ctrl #(.WIN_SCORE(3), .TIMEOUT(20), .RESULT_HOLD(4), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .rnd(rnd), .rnd_en(rnd_en),
    .whose(whose), .hit(hit), .hi(hi), .lo(lo), .score0(score0), .score1(score1),
    .winner_valid(winner_valid), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_code = 4'd15;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if ({rnd_en, whose, hit, hi, lo, winner_valid} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=000000", {rnd_en, whose, hit, hi, lo, winner_valid}); end
    n_checks++; if ({score0, score1} !== 8'h00) begin n_fail++; $display("FAIL reset_scores got=%h exp=00", {score0, score1}); end
    $display("reset: state=%0d scores=%0d/%0d", state, score0, score1);
  endtask

  task automatic test_start();
    int pulses;
    pulses = 0;
    rnd = 5'd23; key_code = 4'd11;
    tick(); pulses += rnd_en;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL start_draw got=%0d exp=1", state); end
    tick(); pulses += rnd_en;
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL start_latch got=%0d exp=2", state); end
    tick(); pulses += rnd_en;
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL start_wait got=%0d exp=3", state); end
    tick(); pulses += rnd_en;
    tick(); pulses += rnd_en;
    key_code = 4'd15; tick(); pulses += rnd_en;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL start_rnd_en_pulses got=%0d exp=1", pulses); end
    n_checks++; if (dut.target_reg !== 4'd3) begin n_fail++; $display("FAIL start_target got=%0d exp=3", dut.target_reg); end
    key_code = 4'd11; tick(); key_code = 4'd15; tick();
    n_checks++; if (state !== 3'd3 || rnd_en !== 1'b0) begin n_fail++; $display("FAIL start_hash_in_wait got=%0d/%b exp=3/0", state, rnd_en); end
    $display("start: round open, rnd_en pulses=%0d", pulses);
  endtask

  // Takes a guess from WAIT_KEY and follows it through CHECK and RESULT to the exit.
  task automatic do_guess(input logic [3:0] d, input int hold, input logic e_hit, input logic e_hi,
                          input logic e_lo, input logic [3:0] e_s0, input logic [3:0] e_s1,
                          input logic [2:0] e_next, input logic e_whose);
    key_code = d;
    tick();
    if (hold == 1) key_code = 4'd15;
    n_checks++; if (state !== 3'd4 || {hit, hi, lo} !== 3'b000) begin n_fail++; $display("FAIL guess_check_state d=%0d got=%0d/%b exp=4/000", d, state, {hit, hi, lo}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i + 2 == hold) key_code = 4'd15;
      n_checks++; if (state !== 3'd5 || {hit, hi, lo} !== {e_hit, e_hi, e_lo}) begin n_fail++; $display("FAIL guess_result d=%0d cyc=%0d got=%0d/%b exp=5/%b", d, i, state, {hit, hi, lo}, {e_hit, e_hi, e_lo}); end
      n_checks++; if (score0 !== e_s0 || score1 !== e_s1) begin n_fail++; $display("FAIL guess_scores d=%0d got=%0d/%0d exp=%0d/%0d", d, score0, score1, e_s0, e_s1); end
    end
    key_code = 4'd15;
    tick();
    n_checks++; if (state !== e_next || whose !== e_whose || {hit, hi, lo} !== 3'b000) begin n_fail++; $display("FAIL guess_exit d=%0d got=%0d/%b/%b exp=%0d/%b/000", d, state, whose, {hit, hi, lo}, e_next, e_whose); end
    if (e_next == 3'd1) begin
      n_checks++; if (rnd_en !== 1'b1) begin n_fail++; $display("FAIL guess_next_rnd_en got=%b exp=1", rnd_en); end
    end
    $display("guess d=%0d: hit/hi/lo=%b%b%b scores=%0d/%0d next=%0d", d, e_hit, e_hi, e_lo, e_s0, e_s1, e_next);
  endtask

  task automatic start_round(input logic [4:0] r);
    rnd = r;
    tick(); tick();
    n_checks++; if (state !== 3'd3 || rnd_en !== 1'b0) begin n_fail++; $display("FAIL round_open got=%0d/%b exp=3/0", state, rnd_en); end
  endtask

  task automatic test_guesses();
    do_guess(4'd3, 3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 3'd1, 1'b1);
    start_round(5'd23);
    do_guess(4'd7, 1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 3'd1, 1'b0);
    start_round(5'd9);
    do_guess(4'd2, 1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 3'd1, 1'b1);
  endtask

  task automatic test_timeout();
    start_round(5'd9);
    for (int k = 12; k <= 14; k++) begin
      key_code = 4'(k); tick(); key_code = 4'd15; tick();
      n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL dead_key k=%0d got=%0d exp=3", k, state); end
    end
    for (int k = 7; k <= 20; k++) begin
      tick();
      if (k == 19) begin
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL timeout_early got=%0d exp=3", state); end
      end
    end
    n_checks++; if (state !== 3'd5 || {hit, hi, lo} !== 3'b000) begin n_fail++; $display("FAIL timeout_result got=%0d/%b exp=5/000", state, {hit, hi, lo}); end
    tick(); tick(); tick(); tick();
    n_checks++; if (state !== 3'd1 || whose !== 1'b0 || score0 !== 4'd1 || score1 !== 4'd0) begin n_fail++; $display("FAIL timeout_exit got=%0d/%b/%0d/%0d exp=1/0/1/0", state, whose, score0, score1); end
    $display("timeout: forfeit after 20 cycles");
    // Digit on the last allowed cycle beats the timeout.
    start_round(5'd9);
    for (int k = 0; k < 19; k++) tick();
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL late_digit_wait got=%0d exp=3", state); end
    do_guess(4'd9, 1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 3'd1, 1'b1);
    start_round(5'd9);
    key_code = 4'd10; tick(); key_code = 4'd15;
    n_checks++; if (state !== 3'd5 || {hit, hi, lo} !== 3'b000) begin n_fail++; $display("FAIL star_forfeit got=%0d/%b exp=5/000", state, {hit, hi, lo}); end
    tick(); tick(); tick(); tick();
    n_checks++; if (state !== 3'd1 || whose !== 1'b0) begin n_fail++; $display("FAIL star_exit got=%0d/%b exp=1/0", state, whose); end
    $display("star: immediate forfeit");
  endtask

  task automatic test_game_over();
    start_round(5'd23);
    do_guess(4'd3, 1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 3'd6, 1'b0);
    n_checks++; if (winner_valid !== 1'b1 || winner !== 1'b0) begin n_fail++; $display("FAIL over_winner got=%b/%b exp=1/0", winner_valid, winner); end
    key_code = 4'd5; tick(); key_code = 4'd15; tick();
    key_code = 4'd10; tick(); key_code = 4'd15; tick();
    n_checks++; if (state !== 3'd6 || score0 !== 4'd3 || winner_valid !== 1'b1 || rnd_en !== 1'b0) begin n_fail++; $display("FAIL over_ignore got=%0d/%0d/%b/%b exp=6/3/1/0", state, score0, winner_valid, rnd_en); end
    key_code = 4'd11; tick(); key_code = 4'd15;
    n_checks++; if (state !== 3'd1 || rnd_en !== 1'b1 || winner_valid !== 1'b0 || whose !== 1'b0) begin n_fail++; $display("FAIL over_restart got=%0d/%b/%b/%b exp=1/1/0/0", state, rnd_en, winner_valid, whose); end
    n_checks++; if (score0 !== 4'd0 || score1 !== 4'd0) begin n_fail++; $display("FAIL over_clear got=%0d/%0d exp=0/0", score0, score1); end
    tick();
    $display("game over: winner=%0d, restarted", winner);
  endtask

  task automatic test_reset_mid_result();
    start_round(5'd23);
    key_code = 4'd3; tick(); key_code = 4'd15; tick();
    n_checks++; if (state !== 3'd5 || hit !== 1'b1 || score0 !== 4'd1) begin n_fail++; $display("FAIL midreset_pre got=%0d/%b/%0d exp=5/1/1", state, hit, score0); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (state !== 3'd0 || hit !== 1'b0 || score0 !== 4'd0) begin n_fail++; $display("FAIL midreset_state got=%0d/%b/%0d exp=0/0/0", state, hit, score0); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (state !== 3'd0 || rnd_en !== 1'b0) begin n_fail++; $display("FAIL midreset_idle cyc=%0d got=%0d/%b exp=0/0", k, state, rnd_en); end
    end
    $display("reset during RESULT: back to IDLE");
  endtask

  initial begin
    test_reset();
    test_start();
    test_guesses();
    test_timeout();
    test_game_over();
    test_reset_mid_result();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
